c2c_adapter_mw: RTL
===================

# c2c_adapter_mw

Parametrised chip-to-chip PHY adapter between the C2C core streaming interface and an MGT 8b10b user port. Generalises the 32-bit adapter to 32/64/128-bit lanes and adds an internal clock-correction (CC) scheduler with overrun detection, a TX link-reset command generator, and multi-word link-reset qualification on RX. Sits directly between the C2C IP and the transceiver wrapper in the `c2c_phy_clk` domain.

## Interface
- `DATA_W`, 32, MGT data width; legal values 32, 64, 128. `K_W = DATA_W/8`.
- `CC_PERIOD`, 5000, internal CC request interval in cycles; 0 disables the internal scheduler.
- `CC_MAX_DEFER`, 64, maximum cycles a CC may stay pending before `cc_overrun` is set.
- `LRST_TX_LEN`, 16, link-reset words sent per `link_reset_req`.
- `LRST_DET`, 4, consecutive RX link-reset words required to trigger.
- `LINK_RST_CYCLES`, 1000, `link_reset` pulse length in cycles.
- `c2c_phy_clk`, in, 1, single clock.
- `c2c_phy_rst_n`, in, 1, asynchronous active-low reset.
- `c2c_tx_tdata`, in, DATA_W, TX data from the C2C core.
- `c2c_tx_tvalid`, in, 1, TX data valid.
- `do_cc`, in, 1, external CC request pulse; ORed with the internal scheduler.
- `link_reset_req`, in, 1, pulse: transmit a link-reset command.
- `mgt_rx_data`, in, DATA_W, RX data from the MGT.
- `mgt_rx_k`, in, K_W, RX charisk.
- `rx_aligned`, in, 1, MGT byte/comma alignment achieved.
- `c2c_rx_data`, out, DATA_W, RX data to the C2C core.
- `c2c_rx_valid`, out, 1, RX data valid.
- `mgt_tx_data`, out, DATA_W, TX data to the MGT.
- `mgt_tx_k`, out, K_W, TX charisk.
- `link_reset`, out, 1, link reset to the C2C core.
- `lrst_tx_busy`, out, 1, link-reset command in progress; TX data is dropped.
- `cc_overrun`, out, 1, sticky: a CC waited longer than `CC_MAX_DEFER`.

## Operation
- Patterns are built per 32-bit segment, replicated `DATA_W/32` times. CC segment: `32'h000050bc`, k `4'b0001`. LRST: all bytes `8'hfc`, all k set. Zero: data 0, k 0. Interruptible TX word: every segment is `32'h001011bc`, `32'h001011fc` or zero.
- CC scheduler: down-counter reloads to `CC_PERIOD-1` and raises `cc_pend` when it reaches 0. `do_cc` also sets `cc_pend`. A request arriving while `cc_pend=1` is merged, not queued. The defer counter runs while `cc_pend=1`. When it reaches `CC_MAX_DEFER`, `cc_overrun` is set and stays set until reset. The CC is still not forced.
- TX FSM states:
  - DATA: priority is LRST > CC > data.
    - `link_reset_req` → LRST and load the word counter.
    - Else if `cc_pend` and (`!tvalid` or the word is interruptible) → emit CC and clear `cc_pend` and the defer counter.
    - Else if `tvalid` → emit `tdata` with k=0.
    - Else → emit zero.
  - LRST: emit LRST for `LRST_TX_LEN` cycles with `lrst_tx_busy=1`, then return to DATA. A `link_reset_req` during LRST restarts the counter. CC requests during LRST are kept pending.
- RX, evaluated in priority order:
  1. Word equals LRST: output zero data, valid 0, and increment the run counter, saturating at `LRST_DET`.
  2. Word equals CC: output zero data, valid 0, and clear the run counter.
  3. Otherwise: pass the data, set `c2c_rx_valid=rx_aligned`, and clear the run counter.
- Link-reset trigger: when the LRST word arrives with the run counter at `LRST_DET-1` or above, `link_reset` is loaded high for `LINK_RST_CYCLES` cycles. A new qualifying LRST word reloads the pulse counter, extending the pulse.

## Timing
- All outputs are registered. Latency is 1 cycle from `mgt_rx_*` to `c2c_rx_*` and from `c2c_tx_*`/requests to `mgt_tx_*`.
- Reset values: `c2c_rx_data=0`, `c2c_rx_valid=0`, `mgt_tx_data=0`, `mgt_tx_k=0`, `link_reset=0`, `lrst_tx_busy=0`, `cc_overrun=0`. All counters are 0 and `cc_pend=0`. The scheduler counter reloads to `CC_PERIOD-1`.
- `link_reset` rises in the cycle after the `LRST_DET`-th consecutive LRST word is presented.
- Assertion of `c2c_phy_rst_n` mid-command aborts LRST transmission and any `link_reset` pulse immediately.
- Simultaneous scheduler expiry and `do_cc` produce one CC.

## Structure
- Package `c2c_pkg` holds:
  - the 32-bit constants `CLKC_D`, `CLKC_K`, `SPAT0/1/2`, `LRST_BYTE`;
  - the TX state enum `c2c_tx_st_t`;
  - the function `c2c_rep(seg, n)` for pattern replication.
- Sub-module `c2c_cc_sched` contains the period counter, `cc_pend` merge, defer counter and `cc_overrun`. It has inputs `do_cc`, `cc_ack` and `cc_hold`, and outputs `cc_pend` and `cc_overrun`.

## Test plan
1. Reset and idle, DATA_W=64, `CC_PERIOD=100`, `tvalid=0` → zero words, with CC `64'h000050bc_000050bc`/k `8'h11` at cycles 100, 200, … after reset release.
2. `tvalid=1` with a non-interruptible word stream (`0xdeadbeef…`) for 80 cycles, and `do_cc` at cycle 0 → no CC and all data passed; `cc_overrun` rises at defer 64. The first spatd0 word is replaced by CC.
3. `link_reset_req` pulse, `LRST_TX_LEN=16` → 16 all-`fc`/all-k words with `lrst_tx_busy=1`; an interruptible word arriving after the command is then replaced by the pending CC.
4. RX: 3 LRST words then a data word → no `link_reset`. 4 LRST words → `link_reset` high for exactly 1000 cycles, and `c2c_rx_valid=0` on all LRST words.
5. RX CC word with `rx_aligned=1` → valid 0 and data 0. Data word with `rx_aligned=0` → data passed, valid 0.
6. `c2c_phy_rst_n` asserted at cycle 500 of a `link_reset` pulse and at word 5 of an LRST send → all outputs return to reset values at once; normal data flows after release.

Source files
------------

// File: rtl/c2c_pkg.sv
// Shared constants, TX state encoding and pattern helpers for the C2C PHY adapter.
package c2c_pkg;

  localparam int unsigned SEG_W   = 32;
  localparam int unsigned SEG_K   = 4;
  localparam int unsigned MAX_SEG = 4;

  localparam logic [SEG_W-1:0] CLKC_D    = 32'h000050bc;
  localparam logic [SEG_K-1:0] CLKC_K    = 4'b0001;
  localparam logic [SEG_W-1:0] SPAT0     = 32'h001011bc;
  localparam logic [SEG_W-1:0] SPAT1     = 32'h001011fc;
  localparam logic [SEG_W-1:0] SPAT2     = 32'h00000000;
  localparam logic [7:0]       LRST_BYTE = 8'hfc;

  typedef enum logic {
    TX_DATA = 1'b0,
    TX_LRST = 1'b1
  } c2c_tx_st_t;

  // Replicate a 32-bit segment into the low n lanes of a 128-bit word.
  function automatic logic [MAX_SEG*SEG_W-1:0] c2c_rep(input logic [SEG_W-1:0] seg,
                                                       input int unsigned n);
    logic [MAX_SEG*SEG_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_SEG; i++) begin
      if (i < n) r[i*SEG_W +: SEG_W] = seg;
    end
    return r;
  endfunction

  // Same replication for the 4-bit per-segment charisk.
  function automatic logic [MAX_SEG*SEG_K-1:0] c2c_rep_k(input logic [SEG_K-1:0] seg,
                                                         input int unsigned n);
    logic [MAX_SEG*SEG_K-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_SEG; i++) begin
      if (i < n) r[i*SEG_K +: SEG_K] = seg;
    end
    return r;
  endfunction

endpackage

// File: rtl/c2c_adapter_mw_cc_sched.sv
// Clock-correction scheduler: periodic request, request merge, defer tracking and sticky overrun.
module c2c_cc_sched #(
  parameter int unsigned CC_PERIOD    = 5000,
  parameter int unsigned CC_MAX_DEFER = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic do_cc,
  input  logic cc_ack,
  input  logic cc_hold,
  output logic cc_pend,
  output logic cc_overrun
);

  localparam int unsigned CW = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;
  localparam int unsigned DW = (CC_MAX_DEFER > 0) ? $clog2(CC_MAX_DEFER + 1) : 1;

  logic          hit_c;
  logic          req_c;
  logic          clr_c;
  logic [DW-1:0] defer_q;

  generate
    if (CC_PERIOD == 0) begin : g_no_sched
      assign hit_c = 1'b0;
    end else begin : g_sched
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_n;

      always_comb cnt_n = (cnt_q == '0) ? CW'(CC_PERIOD - 1) : cnt_q - CW'(1);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= CW'(CC_PERIOD - 1);
        else        cnt_q <= cnt_n;
      end

      // Request fires on the cycle the counter reaches zero.
      assign hit_c = (cnt_n == '0);
    end
  endgenerate

  // Scheduler expiry and external requests collapse into one pending CC.
  assign req_c = do_cc | hit_c;
  assign clr_c = cc_ack & ~cc_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_pend    <= 1'b0;
      defer_q    <= '0;
      cc_overrun <= 1'b0;
    end else begin
      if (req_c)      cc_pend <= 1'b1;
      else if (clr_c) cc_pend <= 1'b0;

      if (clr_c || !cc_pend)                   defer_q <= '0;
      else if (defer_q != DW'(CC_MAX_DEFER))   defer_q <= defer_q + DW'(1);

      if (cc_pend && !clr_c && (defer_q == DW'(CC_MAX_DEFER))) cc_overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/c2c_adapter_mw.sv
// C2C core <-> MGT 8b10b adapter: TX CC/link-reset insertion and RX pattern stripping with link-reset detect.
module c2c_adapter_mw
  import c2c_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned CC_PERIOD       = 5000,
  parameter int unsigned CC_MAX_DEFER    = 64,
  parameter int unsigned LRST_TX_LEN     = 16,
  parameter int unsigned LRST_DET        = 4,
  parameter int unsigned LINK_RST_CYCLES = 1000
) (
  input  logic                c2c_phy_clk,
  input  logic                c2c_phy_rst_n,
  input  logic [DATA_W-1:0]   c2c_tx_tdata,
  input  logic                c2c_tx_tvalid,
  input  logic                do_cc,
  input  logic                link_reset_req,
  input  logic [DATA_W-1:0]   mgt_rx_data,
  input  logic [DATA_W/8-1:0] mgt_rx_k,
  input  logic                rx_aligned,
  output logic [DATA_W-1:0]   c2c_rx_data,
  output logic                c2c_rx_valid,
  output logic [DATA_W-1:0]   mgt_tx_data,
  output logic [DATA_W/8-1:0] mgt_tx_k,
  output logic                link_reset,
  output logic                lrst_tx_busy,
  output logic                cc_overrun
);

  localparam int unsigned K_W  = DATA_W / 8;
  localparam int unsigned NSEG = DATA_W / SEG_W;
  localparam int unsigned LW   = (LRST_TX_LEN > 1) ? $clog2(LRST_TX_LEN) : 1;
  localparam int unsigned RW   = $clog2(LRST_DET + 1);
  localparam int unsigned PW   = (LINK_RST_CYCLES > 1) ? $clog2(LINK_RST_CYCLES) : 1;

  localparam logic [DATA_W-1:0] CC_D   = DATA_W'(c2c_rep(CLKC_D, NSEG));
  localparam logic [K_W-1:0]    CC_K   = K_W'(c2c_rep_k(CLKC_K, NSEG));
  localparam logic [DATA_W-1:0] LRST_D = DATA_W'(c2c_rep({4{LRST_BYTE}}, NSEG));
  localparam logic [K_W-1:0]    LRST_K = K_W'(c2c_rep_k(4'hf, NSEG));

  // ---------------- TX ----------------
  c2c_tx_st_t         st_q, st_n;
  logic [LW-1:0]      cnt_q, cnt_n;
  logic [DATA_W-1:0]  tx_data_n;
  logic [K_W-1:0]     tx_k_n;
  logic               busy_n;
  logic               cc_pend;
  logic               cc_ack_c;
  logic               lrst_c;
  logic               intr_c;

  c2c_cc_sched #(
    .CC_PERIOD    (CC_PERIOD),
    .CC_MAX_DEFER (CC_MAX_DEFER)
  ) u_cc_sched (
    .clk        (c2c_phy_clk),
    .rst_n      (c2c_phy_rst_n),
    .do_cc      (do_cc),
    .cc_ack     (cc_ack_c),
    .cc_hold    (lrst_c),
    .cc_pend    (cc_pend),
    .cc_overrun (cc_overrun)
  );

  // A word may be displaced by CC only if every segment is a filler pattern.
  always_comb begin
    intr_c = 1'b1;
    for (int unsigned i = 0; i < NSEG; i++) begin
      if ((c2c_tx_tdata[i*SEG_W +: SEG_W] != SPAT0) &&
          (c2c_tx_tdata[i*SEG_W +: SEG_W] != SPAT1) &&
          (c2c_tx_tdata[i*SEG_W +: SEG_W] != SPAT2)) intr_c = 1'b0;
    end
  end

  always_comb begin
    st_n      = st_q;
    cnt_n     = cnt_q;
    tx_data_n = '0;
    tx_k_n    = '0;
    busy_n    = 1'b0;
    cc_ack_c  = 1'b0;
    lrst_c    = 1'b0;
    if (link_reset_req) begin
      st_n   = TX_LRST;
      cnt_n  = LW'(LRST_TX_LEN - 1);
      lrst_c = 1'b1;
    end else if ((st_q == TX_LRST) && (cnt_q != '0)) begin
      cnt_n  = cnt_q - LW'(1);
      lrst_c = 1'b1;
    end else begin
      st_n = TX_DATA;
      if (cc_pend && (!c2c_tx_tvalid || intr_c)) begin
        tx_data_n = CC_D;
        tx_k_n    = CC_K;
        cc_ack_c  = 1'b1;
      end else if (c2c_tx_tvalid) begin
        tx_data_n = c2c_tx_tdata;
      end
    end
    if (lrst_c) begin
      tx_data_n = LRST_D;
      tx_k_n    = LRST_K;
      busy_n    = 1'b1;
    end
  end

  always_ff @(posedge c2c_phy_clk or negedge c2c_phy_rst_n) begin
    if (!c2c_phy_rst_n) begin
      st_q         <= TX_DATA;
      cnt_q        <= '0;
      mgt_tx_data  <= '0;
      mgt_tx_k     <= '0;
      lrst_tx_busy <= 1'b0;
    end else begin
      st_q         <= st_n;
      cnt_q        <= cnt_n;
      mgt_tx_data  <= tx_data_n;
      mgt_tx_k     <= tx_k_n;
      lrst_tx_busy <= busy_n;
    end
  end

  // ---------------- RX ----------------
  logic [RW-1:0] run_q;
  logic [PW-1:0] pulse_q;
  logic          is_lrst_c;
  logic          is_cc_c;
  logic          trig_c;

  assign is_lrst_c = (mgt_rx_data == LRST_D) && (mgt_rx_k == LRST_K);
  assign is_cc_c   = (mgt_rx_data == CC_D) && (mgt_rx_k == CC_K);
  assign trig_c    = is_lrst_c && (run_q >= RW'(LRST_DET - 1));

  always_ff @(posedge c2c_phy_clk or negedge c2c_phy_rst_n) begin
    if (!c2c_phy_rst_n) begin
      c2c_rx_data  <= '0;
      c2c_rx_valid <= 1'b0;
      run_q        <= '0;
    end else if (is_lrst_c) begin
      c2c_rx_data  <= '0;
      c2c_rx_valid <= 1'b0;
      if (run_q != RW'(LRST_DET)) run_q <= run_q + RW'(1);
    end else if (is_cc_c) begin
      c2c_rx_data  <= '0;
      c2c_rx_valid <= 1'b0;
      run_q        <= '0;
    end else begin
      c2c_rx_data  <= mgt_rx_data;
      c2c_rx_valid <= rx_aligned;
      run_q        <= '0;
    end
  end

  // Each qualifying LRST word restarts the full pulse length.
  always_ff @(posedge c2c_phy_clk or negedge c2c_phy_rst_n) begin
    if (!c2c_phy_rst_n) begin
      pulse_q    <= '0;
      link_reset <= 1'b0;
    end else if (trig_c) begin
      pulse_q    <= PW'(LINK_RST_CYCLES - 1);
      link_reset <= 1'b1;
    end else if (pulse_q != '0) begin
      pulse_q    <= pulse_q - PW'(1);
      link_reset <= 1'b1;
    end else begin
      link_reset <= 1'b0;
    end
  end

endmodule
